unit_pack_fifo: RTL and testbench

UNIT_PACK_FIFO -- requirements
Module: unit_pack_fifo

---
 rtl/unit_pack_fifo.sv | 248 ++++++++++++++++++++++++
 tb/tb_unit_pack_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : unit_pack_fifo
// Purpose  : Packs variable-length unit runs from source beats into full
//            destination words, queued in a small output FIFO.
// Revision : 1.0
// ============================================================================
module unit_pack_fifo #(
    parameter int  DATA_WIDTH      = 32,
    parameter int  DATA_UNIT       = 8,
    parameter int  USER_INFO_WIDTH = 8,
    parameter int  DEPTH           = 4,
    localparam int UNITS           = DATA_WIDTH / DATA_UNIT,
    localparam int CW              = $clog2(UNITS) + 1,
    localparam int OW              = $clog2(UNITS),
    localparam int LW              = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       src_valid,
    output logic                       src_ready,
    input  logic [DATA_WIDTH-1:0]      src_data,
    input  logic [OW-1:0]              src_offset,
    input  logic [CW-1:0]              src_unit_num,
    input  logic                       src_bgin,
    input  logic [OW-1:0]              src_initial_offset,
    input  logic                       src_done,
    input  logic                       src_last,
    input  logic [USER_INFO_WIDTH-1:0] src_user_info,
    output logic                       dst_valid,
    input  logic                       dst_ready,
    output logic [DATA_WIDTH-1:0]      dst_data,
    output logic [UNITS-1:0]           dst_strb,
    output logic [CW-1:0]              dst_unit_num,
    output logic                       dst_done,
    output logic                       dst_last,
    output logic [USER_INFO_WIDTH-1:0] dst_user_info,
    output logic [LW-1:0]              level,
    output logic                       err
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [CW-1:0]  c_UNITS = CW'(UNITS);
    localparam logic [LW-1:0]  c_DEPTH = LW'(DEPTH);

    // Accumulator state
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_fill;
    logic [OW-1:0]         r_ofst;
    logic                  r_err;

    // FIFO state
    logic [DATA_WIDTH-1:0]      r_mem_data [DEPTH];
    logic [UNITS-1:0]           r_mem_strb [DEPTH];
    logic [CW-1:0]              r_mem_unum [DEPTH];
    logic                       r_mem_done [DEPTH];
    logic                       r_mem_last [DEPTH];
    logic [USER_INFO_WIDTH-1:0] r_mem_user [DEPTH];
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [LW-1:0]              r_level;

    // Beat datapath
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_unit_mask;
    logic [DATA_WIDTH-1:0]   w_units;
    logic [DATA_WIDTH-1:0]   w_base_acc;
    logic [2*DATA_WIDTH-1:0] w_wide;
    logic [CW-1:0]           w_base_fill;
    logic [CW-1:0]           w_nfill;
    logic [CW-1:0]           w_spill;
    logic [OW-1:0]           w_base_ofst;
    logic                    w_full;
    logic [1:0]              w_e;

    logic [DATA_WIDTH-1:0] w_a_data;
    logic [UNITS-1:0]      w_a_strb;
    logic [CW-1:0]         w_a_unum;
    logic                  w_a_done;
    logic                  w_a_last;
    logic [DATA_WIDTH-1:0] w_b_data;
    logic [UNITS-1:0]      w_b_strb;
    logic [CW-1:0]         w_b_unum;
    logic                  w_b_done;
    logic                  w_b_last;

    logic          w_accept;
    logic          w_pop;
    logic [1:0]    w_push_n;
    logic [LW-1:0] w_free;
    logic [PW-1:0] w_wptr1;

    function automatic logic [UNITS-1:0] strb_range(input logic [OW-1:0] lo,
                                                    input logic [CW-1:0] hi);
        logic [UNITS-1:0] s;
        for (int i = 0; i < UNITS; i++) begin
            s[i] = (CW'(i) >= {1'b0, lo}) && (CW'(i) < hi);
        end
        return s;
    endfunction

    always_comb begin
        w_base_fill = src_bgin ? {1'b0, src_initial_offset} : r_fill;
        w_base_ofst = src_bgin ? src_initial_offset : r_ofst;
        w_base_acc  = src_bgin ? '0 : r_acc;

        w_shifted   = src_data >> (DATA_UNIT * int'(src_offset));
        w_unit_mask = '0;
        for (int i = 0; i < UNITS; i++) begin
            if (CW'(i) < src_unit_num) begin
                w_unit_mask[i*DATA_UNIT +: DATA_UNIT] = '1;
            end
        end
        w_units = w_shifted & w_unit_mask;
        // Double-width staging lets the spill land in the upper word directly
        w_wide  = {{DATA_WIDTH{1'b0}}, w_base_acc}
                | ({{DATA_WIDTH{1'b0}}, w_units} << (DATA_UNIT * int'(w_base_fill)));

        w_nfill = w_base_fill + src_unit_num;
        w_full  = (w_nfill >= c_UNITS);
        w_spill = w_nfill - c_UNITS;

        w_e      = 2'd0;
        w_a_data = w_wide[DATA_WIDTH-1:0];
        w_a_unum = w_full ? c_UNITS : w_nfill;
        w_a_strb = strb_range(w_base_ofst, w_a_unum);
        w_a_done = 1'b0;
        w_a_last = 1'b0;
        w_b_data = '0;
        w_b_strb = '0;
        w_b_unum = '0;
        w_b_done = 1'b0;
        w_b_last = 1'b0;

        if (w_full) begin
            w_e = 2'd1;
            if (src_done && (w_spill != '0)) begin
                w_e      = 2'd2;
                w_b_data = w_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                w_b_strb = strb_range('0, w_spill);
                w_b_unum = w_spill;
                w_b_done = 1'b1;
                w_b_last = src_last;
            end else begin
                w_a_done = src_done;
                w_a_last = src_done & src_last;
            end
        end else if (src_done) begin
            // Also covers nfill==0: an empty word that only marks packet end
            w_e      = 2'd1;
            w_a_done = 1'b1;
            w_a_last = src_last;
        end
    end

    assign w_free    = c_DEPTH - r_level;
    assign src_ready = !flush && (w_free >= LW'(w_e));
    assign w_accept  = src_valid && src_ready;
    assign w_pop     = (r_level != '0) && dst_ready && !flush;
    assign w_push_n  = w_accept ? w_e : 2'd0;
    assign w_wptr1   = r_wptr + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_ofst <= '0;
            r_err  <= 1'b0;
        end else if (flush) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_ofst <= '0;
            r_err  <= 1'b0;
        end else begin
            // A new packet arriving over unfinished fill drops that fill
            r_err <= w_accept && src_bgin && (r_fill != '0);
            if (w_accept) begin
                if (src_done) begin
                    r_acc  <= '0;
                    r_fill <= '0;
                    r_ofst <= '0;
                end else if (w_full) begin
                    r_acc  <= w_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                    r_fill <= w_spill;
                    r_ofst <= '0;
                end else begin
                    r_acc  <= w_wide[DATA_WIDTH-1:0];
                    r_fill <= w_nfill;
                    r_ofst <= w_base_ofst;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_strb[i] <= '0;
                r_mem_unum[i] <= '0;
                r_mem_done[i] <= 1'b0;
                r_mem_last[i] <= 1'b0;
                r_mem_user[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_n != 2'd0) begin
                r_mem_data[r_wptr] <= w_a_data;
                r_mem_strb[r_wptr] <= w_a_strb;
                r_mem_unum[r_wptr] <= w_a_unum;
                r_mem_done[r_wptr] <= w_a_done;
                r_mem_last[r_wptr] <= w_a_last;
                r_mem_user[r_wptr] <= src_user_info;
            end
            if (w_push_n == 2'd2) begin
                r_mem_data[w_wptr1] <= w_b_data;
                r_mem_strb[w_wptr1] <= w_b_strb;
                r_mem_unum[w_wptr1] <= w_b_unum;
                r_mem_done[w_wptr1] <= w_b_done;
                r_mem_last[w_wptr1] <= w_b_last;
                r_mem_user[w_wptr1] <= src_user_info;
            end
            r_wptr  <= r_wptr + PW'(w_push_n);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_level <= r_level + LW'(w_push_n) - LW'(w_pop);
        end
    end

    // Stale storage after a flush is hidden by gating on occupancy
    assign dst_valid     = (r_level != '0);
    assign dst_data      = dst_valid ? r_mem_data[r_rptr] : '0;
    assign dst_strb      = dst_valid ? r_mem_strb[r_rptr] : '0;
    assign dst_unit_num  = dst_valid ? r_mem_unum[r_rptr] : '0;
    assign dst_done      = dst_valid ? r_mem_done[r_rptr] : 1'b0;
    assign dst_last      = dst_valid ? r_mem_last[r_rptr] : 1'b0;
    assign dst_user_info = dst_valid ? r_mem_user[r_rptr] : '0;
    assign level         = r_level;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_unit_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_unit_pack_fifo
// Purpose  : Directed scoreboard bench for unit_pack_fifo (32-bit, 4 units).
// Revision : 1.0
// ============================================================================
module tb_unit_pack_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [31:0] src_data = '0;
    logic [1:0]  src_offset = '0;
    logic [2:0]  src_unit_num = '0;
    logic        src_bgin = 1'b0;
    logic [1:0]  src_initial_offset = '0;
    logic        src_done = 1'b0;
    logic        src_last = 1'b0;
    logic [7:0]  src_user_info = '0;
    logic        dst_valid;
    logic        dst_ready = 1'b0;
    logic [31:0] dst_data;
    logic [3:0]  dst_strb;
    logic [2:0]  dst_unit_num;
    logic        dst_done;
    logic        dst_last;
    logic [7:0]  dst_user_info;
    logic [2:0]  level;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  u;
        logic        dn;
        logic        l;
        logic [7:0]  ui;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    unit_pack_fifo #(
        .DATA_WIDTH(32), .DATA_UNIT(8), .USER_INFO_WIDTH(8), .DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_offset(src_offset), .src_unit_num(src_unit_num), .src_bgin(src_bgin),
        .src_initial_offset(src_initial_offset), .src_done(src_done),
        .src_last(src_last), .src_user_info(src_user_info),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
        .dst_strb(dst_strb), .dst_unit_num(dst_unit_num), .dst_done(dst_done),
        .dst_last(dst_last), .dst_user_info(dst_user_info),
        .level(level), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] s, input logic [2:0] u,
                                input logic dn, input logic l, input logic [7:0] ui);
        exp_t e;
        e.d = d; e.s = s; e.u = u; e.dn = dn; e.l = l; e.ui = ui;
        return e;
    endfunction

    // Each negedge with valid&&ready precedes exactly one pop at the next posedge
    always @(negedge clk) begin
        if (rst_n && !flush && dst_valid && dst_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(dst_data), 64'hDEAD);
            end else begin
                mon_e = sb.pop_front();
                chk("dst_data", 64'(dst_data), 64'(mon_e.d));
                chk("dst_strb", 64'(dst_strb), 64'(mon_e.s));
                chk("dst_unit_num", 64'(dst_unit_num), 64'(mon_e.u));
                chk("dst_done", 64'(dst_done), 64'(mon_e.dn));
                chk("dst_last", 64'(dst_last), 64'(mon_e.l));
                chk("dst_user_info", 64'(dst_user_info), 64'(mon_e.ui));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic bg, input logic [1:0] init, input logic [1:0] off,
                            input logic [2:0] un, input logic dn, input logic ls,
                            input logic [31:0] d, input logic [7:0] ui);
        src_bgin = bg; src_initial_offset = init; src_offset = off;
        src_unit_num = un; src_done = dn; src_last = ls; src_data = d; src_user_info = ui;
    endtask

    task automatic send(input logic bg, input logic [1:0] init, input logic [1:0] off,
                        input logic [2:0] un, input logic dn, input logic ls,
                        input logic [31:0] d, input logic [7:0] ui);
        bit ok = 0;
        set_beat(bg, init, off, un, dn, ls, d, ui);
        src_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (src_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        nxt();
        src_valid = 1'b0;
        set_beat(1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 32'h0, 8'h0);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || dst_valid) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        nxt();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dst_valid", 64'(dst_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_dst_data", 64'(dst_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(src_ready), 64'd1);
        nxt();

        // Single beat with initial offset, one-cycle latency
        dst_ready = 1'b1;
        sb.push_back(mk(32'hCCBBAA00, 4'b1110, 3'd4, 1'b1, 1'b1, 8'h5A));
        send(1'b1, 2'd1, 2'd0, 3'd3, 1'b1, 1'b1, 32'hDDCCBBAA, 8'h5A);
        @(negedge clk);
        chk("latency_valid", 64'(dst_valid), 64'd1);
        nxt();
        drain();

        // Two-beat spill
        sb.push_back(mk(32'hDDCCBBAA, 4'b1111, 3'd4, 1'b0, 1'b0, 8'h22));
        sb.push_back(mk(32'h000000EE, 4'b0001, 3'd1, 1'b1, 1'b1, 8'h22));
        send(1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 32'h0000BBAA, 8'h11);
        send(1'b0, 2'd0, 2'd0, 3'd3, 1'b1, 1'b1, 32'h00EEDDCC, 8'h22);
        drain();

        // Source offsets, spill without last
        sb.push_back(mk(32'h77664433, 4'b1111, 3'd4, 1'b0, 1'b0, 8'h34));
        sb.push_back(mk(32'h00000088, 4'b0001, 3'd1, 1'b1, 1'b0, 8'h34));
        send(1'b1, 2'd0, 2'd2, 3'd2, 1'b0, 1'b0, 32'h44332211, 8'h33);
        send(1'b0, 2'd0, 2'd1, 3'd3, 1'b1, 1'b0, 32'h88776655, 8'h34);
        drain();

        // Empty done word, then exact-fill done word
        sb.push_back(mk(32'h0, 4'b0000, 3'd0, 1'b1, 1'b1, 8'h40));
        send(1'b1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 8'h40);
        sb.push_back(mk(32'hBBAA0000, 4'b1100, 3'd4, 1'b1, 1'b1, 8'h41));
        send(1'b1, 2'd2, 2'd0, 3'd2, 1'b1, 1'b1, 32'h1234BBAA, 8'h41);
        drain();

        // Backpressure and E-dependent src_ready
        dst_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            sb.push_back(mk(32'hA0A0A0A0 + 32'(p), 4'b1111, 3'd4, 1'b1, 1'b0, 8'(p)));
            send(1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 32'hA0A0A0A0 + 32'(p), 8'(p));
        end
        @(negedge clk);
        chk("bp_level3", 64'(level), 64'd3);
        nxt();
        send(1'b1, 2'd0, 2'd0, 3'd3, 1'b0, 1'b0, 32'hFF332211, 8'h50);
        set_beat(1'b0, 2'd0, 2'd0, 3'd3, 1'b1, 1'b1, 32'h00665544, 8'h51);
        src_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_e2", 64'(src_ready), 64'd0);
        nxt();
        sb.push_back(mk(32'h44332211, 4'b1111, 3'd4, 1'b1, 1'b1, 8'h52));
        set_beat(1'b0, 2'd0, 2'd0, 3'd1, 1'b1, 1'b1, 32'h00000044, 8'h52);
        @(negedge clk);
        chk("bp_ready_e1", 64'(src_ready), 64'd1);
        nxt();
        set_beat(1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 32'h99999999, 8'h53);
        @(negedge clk);
        chk("bp_level4", 64'(level), 64'd4);
        chk("bp_ready_full", 64'(src_ready), 64'd0);
        nxt();
        src_valid = 1'b0;
        set_beat(1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 32'h0, 8'h0);
        dst_ready = 1'b1;
        drain();

        // Flush with partial fill and three queued words
        dst_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            send(1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 32'hB0B0B0B0 + 32'(p), 8'h60);
        end
        send(1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 32'h0000C1C0, 8'h61);
        flush = 1'b1;
        dst_ready = 1'b1;
        set_beat(1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 32'h77777777, 8'h62);
        src_valid = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(src_ready), 64'd0);
        nxt();
        flush = 1'b0;
        src_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_valid", 64'(dst_valid), 64'd0);
        nxt();
        sb.push_back(mk(32'hAB000000, 4'b1000, 3'd4, 1'b1, 1'b1, 8'h63));
        send(1'b1, 2'd3, 2'd0, 3'd1, 1'b1, 1'b1, 32'h000000AB, 8'h63);
        drain();

        // Restart over unfinished packet
        send(1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 32'h00002211, 8'h70);
        sb.push_back(mk(32'hCCBBAA00, 4'b1110, 3'd4, 1'b1, 1'b0, 8'h71));
        send(1'b1, 2'd1, 2'd0, 3'd3, 1'b1, 1'b0, 32'h00CCBBAA, 8'h71);
        @(negedge clk);
        chk("err_pulse", 64'(err), 64'd1);
        nxt();
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'd0);
        nxt();
        drain();

        // Reset mid-packet
        dst_ready = 1'b0;
        send(1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 32'hD0D0D0D0, 8'h80);
        send(1'b1, 2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 32'hD1D1D1D1, 8'h81);
        send(1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 32'h0000D3D2, 8'h82);
        @(negedge clk);
        chk("pre_rst_level", 64'(level), 64'd2);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(dst_valid), 64'd0);
        chk("rst_mid_level", 64'(level), 64'd0);
        chk("rst_mid_data", 64'(dst_data), 64'd0);
        chk("rst_mid_strb", 64'(dst_strb), 64'd0);
        sb.delete();
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 64'(src_ready), 64'd1);
        nxt();
        dst_ready = 1'b1;
        sb.push_back(mk(32'h00002211, 4'b0011, 3'd2, 1'b1, 1'b1, 8'h90));
        send(1'b0, 2'd0, 2'd0, 3'd2, 1'b1, 1'b1, 32'h00002211, 8'h90);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
